// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM: fetch/decode/exec/mem/wb sequencing,
// next-PC select strobes, datapath controls and a retired-instruction counter.
module mips_multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        Branch,
  output logic        Jump,
  output logic        JR,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        ALUSrc,
  output logic        ExtOp,
  output logic [2:0]  ALUCtrl,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        Retire,
  output logic        Illegal,
  output logic [31:0] InstrCount,
  output logic [2:0]  State
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_XORI = 6'b001110;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;

  state_t      state_q;
  logic [5:0]  op_q;
  logic [5:0]  fn_q;
  logic [31:0] count_q;

  logic is_r, is_lw, is_sw, is_j, is_bne, is_xori;
  logic is_add, is_sub, is_slt, is_jr;
  logic is_alu_r, is_mem, is_illegal;
  logic [2:0] r_ctrl;

  // Only the opcode/funct fields steer control; Zero is consumed by fetch.
  logic unused_bits;
  assign unused_bits = ^{Zero, Instr[25:6]};

  assign is_r     = (op_q == OP_R);
  assign is_lw    = (op_q == OP_LW);
  assign is_sw    = (op_q == OP_SW);
  assign is_j     = (op_q == OP_J);
  assign is_bne   = (op_q == OP_BNE);
  assign is_xori  = (op_q == OP_XORI);
  assign is_add   = is_r && (fn_q == FN_ADD);
  assign is_sub   = is_r && (fn_q == FN_SUB);
  assign is_slt   = is_r && (fn_q == FN_SLT);
  assign is_jr    = is_r && (fn_q == FN_JR);
  assign is_alu_r = is_add | is_sub | is_slt;
  assign is_mem   = is_lw | is_sw;

  assign is_illegal = ~(is_alu_r | is_jr | is_mem | is_j |
                        is_bne | is_xori);

  always_comb begin
    r_ctrl = ALU_ADD;
    unique case (1'b1)
      is_sub:  r_ctrl = ALU_SUB;
      is_slt:  r_ctrl = ALU_SLT;
      default: r_ctrl = ALU_ADD;
    endcase
  end

  always_comb begin
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    Jump     = 1'b0;
    JR       = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    ALUSrc   = 1'b0;
    ExtOp    = 1'b0;
    ALUCtrl  = ALU_ADD;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemToReg = 1'b0;
    Illegal  = 1'b0;
    // Reset forces every control low, aborting any in-flight access.
    if (!reset) begin
      case (state_q)
        S_FETCH: IRWrite = 1'b1;
        S_DECODE: begin
          if (is_j) begin
            PCWrite = 1'b1;
            Jump    = 1'b1;
          end else if (is_jr) begin
            PCWrite = 1'b1;
            Jump    = 1'b1;
            JR      = 1'b1;
          end else if (is_illegal) begin
            PCWrite = 1'b1;
            Illegal = 1'b1;
          end
        end
        S_EXEC: begin
          if (is_bne) begin
            ALUCtrl = ALU_SUB;
            Branch  = 1'b1;
            PCWrite = 1'b1;
          end else if (is_alu_r) begin
            ALUCtrl = r_ctrl;
          end else if (is_xori) begin
            ALUCtrl = ALU_XOR;
            ALUSrc  = 1'b1;
          end else if (is_mem) begin
            ALUSrc = 1'b1;
            ExtOp  = 1'b1;
          end
        end
        S_MEM: begin
          ALUSrc = 1'b1;
          ExtOp  = 1'b1;
          if (is_lw) begin
            MemRead = 1'b1;
          end else begin
            MemWrite = 1'b1;
            PCWrite  = MemReady;
          end
        end
        S_WB: begin
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          if (is_lw) begin
            MemToReg = 1'b1;
          end else if (is_r) begin
            RegDst = 1'b1;
          end else begin
            ALUSrc  = 1'b1;
            ALUCtrl = ALU_XOR;
          end
        end
        default: ;
      endcase
    end
  end

  assign Retire     = PCWrite;
  assign InstrCount = count_q;
  assign State      = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= 6'd0;
      fn_q    <= 6'd0;
      count_q <= 32'd0;
    end else begin
      if (Retire)
        count_q <= count_q + 32'd1;
      case (state_q)
        S_FETCH: begin
          op_q    <= Instr[31:26];
          fn_q    <= Instr[5:0];
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (is_j || is_jr || is_illegal)
            state_q <= S_FETCH;
          else
            state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (is_bne)
            state_q <= S_FETCH;
          else if (is_mem)
            state_q <= S_MEM;
          else
            state_q <= S_WB;
        end
        S_MEM: begin
          if (MemReady)
            state_q <= is_lw ? S_WB : S_FETCH;
        end
        S_WB:    state_q <= S_FETCH;
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-instruction state trace,
// cycle count, final-cycle controls and retired-instruction count.
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic        Zero;
  logic        MemReady;
  logic        IRWrite, PCWrite, Branch, Jump, JR;
  logic        RegWrite, RegDst, ALUSrc, ExtOp;
  logic [2:0]  ALUCtrl;
  logic        MemRead, MemWrite, MemToReg;
  logic        Retire, Illegal;
  logic [31:0] InstrCount;
  logic [2:0]  State;

  int total = 0;
  int bad   = 0;

  int          cyc, pcw_n, regw_n, memw_n, memr_n, ill_n, wcnt;
  logic [31:0] trace;
  logic        f_br, f_j, f_jr, f_rw, f_rd, f_as, f_eo;
  logic        f_mtr, f_ill, f_ret;
  logic [2:0]  f_alu;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Instr(Instr), .Zero(Zero),
    .MemReady(MemReady), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .Branch(Branch), .Jump(Jump), .JR(JR), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .ExtOp(ExtOp),
    .ALUCtrl(ALUCtrl), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemToReg(MemToReg), .Retire(Retire), .Illegal(Illegal),
    .InstrCount(InstrCount), .State(State)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the FSM in FETCH; returns at the negedge
  // after the instruction's PCWrite edge.
  task run(input logic [31:0] ins, input int waits, input logic z);
    logic done;
    cyc = 0; pcw_n = 0; regw_n = 0; memw_n = 0; memr_n = 0;
    ill_n = 0; wcnt = 0; trace = 0; done = 1'b0;
    Instr = ins;
    Zero  = z;
    for (int i = 0; i < 20 && !done; i++) begin
      if (i > 0)
        Instr = ~ins;
      if (State == 3'd3) begin
        MemReady = (wcnt >= waits);
        wcnt++;
      end else begin
        MemReady = 1'b1;
      end
      #1;
      trace  = {trace[28:0], State};
      pcw_n  += int'(PCWrite);
      regw_n += int'(RegWrite);
      memw_n += int'(MemWrite);
      memr_n += int'(MemRead);
      ill_n  += int'(Illegal);
      if (PCWrite) begin
        cyc = i + 1;
        f_br = Branch; f_j = Jump; f_jr = JR; f_rw = RegWrite;
        f_rd = RegDst; f_as = ALUSrc; f_eo = ExtOp; f_alu = ALUCtrl;
        f_mtr = MemToReg; f_ill = Illegal; f_ret = Retire;
        done = 1'b1;
      end
      @(negedge clk);
    end
    MemReady = 1'b1;
    if (!done)
      chk("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b1; Instr = 32'h0; Zero = 1'b0; MemReady = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_irw", {31'd0, IRWrite}, 32'd0);
    chk("rst_pcw", {31'd0, PCWrite}, 32'd0);
    chk("rst_state", {29'd0, State}, 32'd0);
    chk("rst_cnt", InstrCount, 32'd0);
    reset = 1'b0;
    #1;
    chk("first_irw", {31'd0, IRWrite}, 32'd1);

    // ADD $3,$1,$2
    run(32'h0022_1820, 0, 1'b0);
    chk("add_trace", trace, 32'o124);
    chk("add_cyc", cyc, 32'd4);
    chk("add_wb", {f_rw, f_rd, f_as, f_mtr, f_ret}, 32'b11001);
    chk("add_alu", {29'd0, f_alu}, 32'd0);
    chk("add_cnt", InstrCount, 32'd1);

    // LW with two wait cycles
    run(32'h8C22_0004, 2, 1'b0);
    chk("lw_trace", trace, 32'o123334);
    chk("lw_cyc", cyc, 32'd7);
    chk("lw_memr", memr_n, 32'd3);
    chk("lw_wb", {f_rw, f_rd, f_mtr}, 32'b101);
    chk("lw_pcw", pcw_n, 32'd1);
    chk("lw_cnt", InstrCount, 32'd2);

    // BNE, not-taken and taken; control is identical
    for (int k = 0; k < 2; k++) begin
      run(32'h1422_0003, 0, k[0]);
      chk("bne_trace", trace, 32'o12);
      chk("bne_cyc", cyc, 32'd3);
      chk("bne_ctl", {f_br, f_j, f_as, f_alu}, 32'b100001);
      chk("bne_nowr", regw_n + memw_n, 32'd0);
    end
    chk("bne_cnt", InstrCount, 32'd4);

    // J then JR $31
    run(32'h0800_0010, 0, 1'b0);
    chk("j_cyc", cyc, 32'd2);
    chk("j_sel", {f_br, f_j, f_jr}, 32'b010);
    run(32'h03E0_0008, 0, 1'b0);
    chk("jr_cyc", cyc, 32'd2);
    chk("jr_sel", {f_br, f_j, f_jr}, 32'b011);
    chk("jr_cnt", InstrCount, 32'd6);

    // Illegal opcode 0x3F
    run(32'hFC00_0000, 0, 1'b0);
    chk("ill_trace", trace, 32'o1);
    chk("ill_pulse", {f_ill, f_j}, 32'b10);
    chk("ill_n", ill_n, 32'd1);
    chk("ill_noreg", regw_n, 32'd0);
    chk("ill_cnt", InstrCount, 32'd7);

    // XORI: zero-extended immediate, XOR through WB
    run(32'h3822_0005, 0, 1'b0);
    chk("xori_trace", trace, 32'o124);
    chk("xori_wb", {f_rw, f_rd, f_as, f_eo, f_mtr}, 32'b10100);
    chk("xori_alu", {29'd0, f_alu}, 32'd3);

    // SW, zero wait
    run(32'hAC22_0004, 0, 1'b0);
    chk("sw_trace", trace, 32'o123);
    chk("sw_cyc", cyc, 32'd4);
    chk("sw_memw", memw_n, 32'd1);
    chk("sw_noreg", regw_n, 32'd0);

    // R-type with unsupported funct (ADDU)
    run(32'h0022_1821, 0, 1'b0);
    chk("badfn_cyc", cyc, 32'd2);
    chk("badfn_ill", {31'd0, f_ill}, 32'd1);
    chk("badfn_cnt", InstrCount, 32'd10);

    // Reset asserted while SW is stalled in MEM
    Instr = 32'hAC22_0004;
    MemReady = 1'b0;
    repeat (3) @(negedge clk);
    MemReady = 1'b0;
    #1;
    chk("swst_state", {29'd0, State}, 32'd3);
    chk("swst_memw", {31'd0, MemWrite}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_memw", {31'd0, MemWrite}, 32'd0);
    chk("abort_pcw", {31'd0, PCWrite}, 32'd0);
    chk("abort_state", {29'd0, State}, 32'd0);
    chk("abort_cnt", InstrCount, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    MemReady = 1'b1;
    #1;
    chk("rerun_irw", {31'd0, IRWrite}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
